// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - coin codes and emitter state shared by coin acceptor and vending FSM
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_RSVD = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } emit_state_t;

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - two-flop synchroniser, debounce counter and rising-edge pulse for one sensor
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic rise_o
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; the next mismatch cycle commits the level.
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive cycles where the synchronised input differs from the debounced level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, debounce state and a registered one-cycle rise pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= level_d & ~level_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced coin sensors feeding an event FIFO and a one-cycle code emitter
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int REJ_W           = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               coin5_raw,
    input  logic                               coin10_raw,
    input  logic                               inhibit,
    output logic [1:0]                         coin_code,
    output logic                               coin_reject,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic [REJ_W-1:0]                   reject_count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic              rise5;
    logic              rise10;
    logic [1:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [REJ_W-1:0]  rej_cnt_q;
    logic [REJ_W-1:0]  rej_cnt_d;
    logic              reject_q;
    logic              reject_d;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              full;
    logic [1:0]        push_code;
    emit_state_t       state_q;
    emit_state_t       state_d;
    logic [1:0]        code_q;
    logic [1:0]        code_d;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db5 (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (coin5_raw),
        .rise_o (rise5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db10 (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (coin10_raw),
        .rise_o (rise10)
    );

    // Event classification, FIFO admission and saturating reject accounting.
    always_comb begin
        push_req  = rise5 ^ rise10;
        push_code = rise5 ? COIN_5 : COIN_10;
        full      = (count_q == CW'(FIFO_DEPTH));
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push      = push_req && (!full || pop);
        reject_d  = (rise5 && rise10) || (push_req && full && !pop);
        rej_cnt_d = rej_cnt_q;
        if (reject_d && (rej_cnt_q != '1)) begin
            rej_cnt_d = rej_cnt_q + 1'b1;
        end
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Emitter: pop only from IDLE so every code is followed by at least one 00 cycle.
    always_comb begin
        state_d = state_q;
        code_d  = COIN_NONE;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !inhibit) begin
                    pop     = 1'b1;
                    state_d = EMIT;
                    code_d  = mem_q[rd_ptr_q];
                end
            end
            EMIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage, pointers, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= COIN_NONE;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rej_cnt_q <= '0;
            reject_q  <= 1'b0;
            state_q   <= IDLE;
            code_q    <= COIN_NONE;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_code;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q   <= count_d;
            rej_cnt_q <= rej_cnt_d;
            reject_q  <= reject_d;
            state_q   <= state_d;
            code_q    <= code_d;
        end
    end

    assign coin_code    = code_q;
    assign coin_reject  = reject_q;
    assign fifo_count   = count_q;
    assign reject_count = rej_cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - table-driven and directed self-checking bench for coin_acceptor
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin5_raw;
    logic       coin10_raw;
    logic       inhibit;
    logic [1:0] coin_code;
    logic       coin_reject;
    logic [2:0] fifo_count;
    logic [7:0] reject_count;

    int checks   = 0;
    int failures = 0;

    int n5_tot  = 0;
    int n10_tot = 0;
    int rej_tot = 0;
    int bad_tot = 0;
    logic [1:0] prev_code = 2'b00;

    typedef struct {
        logic [15:0] p5;
        logic [15:0] p10;
        int          e5;
        int          e10;
        int          erej;
    } vec_t;

    vec_t tbl [6];

    coin_acceptor #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4),
        .REJ_W          (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin5_raw    (coin5_raw),
        .coin10_raw   (coin10_raw),
        .inhibit      (inhibit),
        .coin_code    (coin_code),
        .coin_reject  (coin_reject),
        .fifo_count   (fifo_count),
        .reject_count (reject_count)
    );

    always #5 clk = ~clk;

    // Output monitor: tallies codes and reject pulses, flags 11 codes and repeated codes.
    always @(negedge clk) begin
        if (rst) begin
            if (coin_code == 2'b01) n5_tot <= n5_tot + 1;
            if (coin_code == 2'b10) n10_tot <= n10_tot + 1;
            if (coin_reject) rej_tot <= rej_tot + 1;
            if ((coin_code == 2'b11) || ((coin_code != 2'b00) && (coin_code == prev_code)))
                bad_tot <= bad_tot + 1;
        end
        prev_code <= coin_code;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic coin_pulse(input logic c5, input logic c10);
        coin5_raw  = c5;
        coin10_raw = c10;
        step(6);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        step(8);
    endtask

    initial begin
        int s5, s10, srej, sbad, srcnt;
        logic [1:0] exp_seq [8];

        tbl[0] = '{16'h03FF, 16'h0000, 1, 0, 0};
        tbl[1] = '{16'h0000, 16'h0007, 0, 0, 0};
        tbl[2] = '{16'h5555, 16'h0005, 0, 0, 0};
        tbl[3] = '{16'h03FF, 16'h03FF, 0, 0, 1};
        tbl[4] = '{16'h0000, 16'h03FF, 0, 1, 0};
        tbl[5] = '{16'h0F0F, 16'h0000, 2, 0, 0};

        rst        = 1'b0;
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        inhibit    = 1'b0;
        step(3);
        check("rst_code", int'(coin_code), 0);
        check("rst_reject", int'(coin_reject), 0);
        check("rst_fifo", int'(fifo_count), 0);
        check("rst_rejcnt", int'(reject_count), 0);
        rst = 1'b1;
        step(2);

        // Latency: raw rise sampled at edge 0, code valid after edge 7, gone after edge 8.
        coin5_raw = 1'b1;
        step(7);
        check("lat_edge6", int'(coin_code), 0);
        step(1);
        check("lat_edge7", int'(coin_code), 1);
        step(1);
        check("lat_edge8", int'(coin_code), 0);
        coin5_raw = 1'b0;
        step(20);

        for (int i = 0; i < 6; i++) begin
            s5 = n5_tot; s10 = n10_tot; srej = rej_tot; sbad = bad_tot;
            srcnt = int'(reject_count);
            for (int c = 0; c < 16; c++) begin
                coin5_raw  = tbl[i].p5[c];
                coin10_raw = tbl[i].p10[c];
                step(1);
            end
            coin5_raw  = 1'b0;
            coin10_raw = 1'b0;
            step(24);
            check($sformatf("vec%0d_n5", i), n5_tot - s5, tbl[i].e5);
            check($sformatf("vec%0d_n10", i), n10_tot - s10, tbl[i].e10);
            check($sformatf("vec%0d_rejpulse", i), rej_tot - srej, tbl[i].erej);
            check($sformatf("vec%0d_rejcnt", i), int'(reject_count), srcnt + tbl[i].erej);
            check($sformatf("vec%0d_fifo", i), int'(fifo_count), 0);
            check($sformatf("vec%0d_protocol", i), bad_tot - sbad, 0);
        end

        // FIFO overflow under inhibit, then drain as alternating 01/00.
        inhibit = 1'b1;
        srej  = rej_tot;
        srcnt = int'(reject_count);
        repeat (5) coin_pulse(1'b1, 1'b0);
        step(10);
        check("full_fifo", int'(fifo_count), 4);
        check("full_rejpulse", rej_tot - srej, 1);
        check("full_rejcnt", int'(reject_count), srcnt + 1);
        check("full_no_code", int'(coin_code), 0);
        exp_seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        inhibit = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            check($sformatf("drain_%0d", k), int'(coin_code), int'(exp_seq[k]));
        end
        check("drain_fifo", int'(fifo_count), 0);
        step(5);

        // Arrival order preserved: coin5 then coin10.
        inhibit = 1'b1;
        coin_pulse(1'b1, 1'b0);
        coin_pulse(1'b0, 1'b1);
        step(10);
        check("order_fifo", int'(fifo_count), 2);
        exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        inhibit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check($sformatf("order_%0d", k), int'(coin_code), int'(exp_seq[k]));
        end
        step(5);

        // Reset asserted during EMIT with a coin still buffered.
        inhibit = 1'b1;
        coin_pulse(1'b1, 1'b0);
        coin_pulse(1'b1, 1'b0);
        step(10);
        inhibit = 1'b0;
        step(1);
        check("mid_emit_code", int'(coin_code), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_code", int'(coin_code), 0);
        check("async_fifo", int'(fifo_count), 0);
        check("async_rejcnt", int'(reject_count), 0);
        check("async_reject", int'(coin_reject), 0);
        step(2);
        rst = 1'b1;
        s5 = n5_tot; s10 = n10_tot;
        step(20);
        check("post_rst_silent", (n5_tot - s5) + (n10_tot - s10), 0);

        // Saturation of the reject counter.
        srej = rej_tot;
        repeat (260) coin_pulse(1'b1, 1'b1);
        check("sat_rejcnt", int'(reject_count), 255);
        check("sat_pulses", rej_tot - srej, 260);

        // Sensor held high through reset release yields exactly one event.
        rst = 1'b0;
        coin5_raw = 1'b1;
        step(2);
        rst = 1'b1;
        s5 = n5_tot;
        step(20);
        check("held_through_rst", n5_tot - s5, 1);
        coin5_raw = 1'b0;
        step(10);
        check("final_protocol", bad_tot, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage directly upstream of the vending machine FSM. It conditions two raw coin-sensor lines (5-unit and 10-unit) with synchronisation and debouncing, and turns each debounced rising edge into a coin event. Events are buffered in a small FIFO and emitted on the 2-bit coin code bus that drives the vending FSM's `in` input. Each code is valid for exactly one cycle, followed by at least one 00 cycle.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before the debounced level changes (min 1)
FIFO_DEPTH, 4, coin events buffered (power of 2, min 2)
REJ_W, 8, width of saturating reject counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
coin5_raw  input  1  raw 5-unit sensor, active high, asynchronous to clk
coin10_raw  input  1  raw 10-unit sensor, active high, asynchronous to clk
inhibit  input  1  1 = hold emitter idle; FIFO still accepts events
coin_code  output  2  00 none, 01 coin5, 10 coin10, 11 never driven
coin_reject  output  1  one-cycle pulse per rejected coin (drives return flap)
fifo_count  output  $clog2(FIFO_DEPTH+1)  entries currently buffered
reject_count  output  REJ_W  saturating count of rejected coins

Behaviour:
- Reset (rst=0): async clear of all flops. coin_code=00, coin_reject=0, fifo_count=0, reject_count=0. Sync flops, debounced levels and debounce counters all =0. FIFO is emptied.
- Sync: 2-flop synchroniser per sensor.
- Debounce, per sensor: counter increments while synced != debounced and clears on equality. When it reaches DEBOUNCE_CYCLES, debounced takes the synced value and the counter clears.
- Event: debounced 0->1 on one sensor only. Falling edges produce no event.
- Latency: raw rise sampled at edge 0, FIFO empty, inhibit=0 -> coin_code valid after exactly 3+DEBOUNCE_CYCLES edges (7 at default).
- Both debounced levels rise on the same cycle: no push, coin_reject pulse, reject_count+1.
- Push when FIFO is full and no pop happens in the same cycle: event dropped, coin_reject pulse, reject_count+1.
- Push when full with a simultaneous pop: accepted, count unchanged.
- reject_count saturates at all-ones.
- Emitter FSM, registered output:
  - IDLE (coin_code=00): if FIFO not empty and inhibit=0, pop and go to EMIT with coin_code=entry; otherwise stay.
  - EMIT: coin_code held one cycle, then unconditionally return to IDLE with coin_code=00.
  - Result: back-to-back codes appear as 01,00,01,00... and a continuous stream is never the same code on two consecutive cycles.
- inhibit raised while in EMIT does not truncate the current code; it blocks the next pop.
- Push and pop in the same cycle: fifo_count unchanged, order preserved (FIFO order = event order).
- Sensor held high through reset release: debounced starts at 0, so one event is generated after the debounce period.
- Reset asserted mid-operation: outputs clear immediately, buffered coins are discarded, and no code is emitted after release unless a sensor rises again.

Decomposition:
- Shared package vm_pkg holds:
  - Coin code constants: COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10, COIN_RSVD=2'b11.
  - Emitter state typedef: IDLE, EMIT.
- The vending FSM imports the same coin constants.
- One sub-module, coin_debounce: synchroniser, counter and debounced level, plus a rise pulse output. It is instantiated twice and parameterised by DEBOUNCE_CYCLES.
- FIFO and emitter stay inline.

Test Plan:
1. coin5_raw high for 10 cycles, inhibit=0 -> coin_code=01 for exactly one cycle, 7 edges after the rise; then 00; reject_count=0, fifo_count back to 0.
2. coin10_raw high for 3 cycles (glitch below DEBOUNCE_CYCLES), and bounce patterns 1-0-1-0 -> coin_code stays 00, no coin_reject.
3. coin5_raw and coin10_raw rise together, held 10 cycles -> one coin_reject pulse, reject_count=1, coin_code stays 00 throughout.
4. inhibit=1, five separate coin5 events:
   - fifo_count reaches 4; fifth event -> coin_reject pulse, reject_count=1.
   - Drop inhibit -> coin_code sequence 01,00,01,00,01,00,01,00, then fifo_count=0.
5. Interleaved coin5 then coin10 events with inhibit=1, then release -> codes emerge 01 then 10 in arrival order, separated by one 00 cycle.
6. Two entries buffered, rst pulsed low mid-EMIT -> coin_code=00 asynchronously, fifo_count=0, reject_count=0; no code for 20 cycles after release.
